multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control unit.
// Sequences each instruction through FETCH/DECODE/execute/writeback states and
// drives the datapath mux selects and enables straight from the current state.
// Optional instruction-set extensions (extra branches, extra ALU ops) are
// selected by parameters; anything not enabled decodes to TRAP.

module multicycle_controller #(
    parameter int EXT_BRANCH = 1,
    parameter int EXT_ALU    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic        zero,
    input  logic        lt,
    output logic        pc_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic [3:0]  ALUControl,
    output logic        retire,
    output logic        illegal,
    output logic [3:0]  state
);

    // Major opcodes recognised by the decoder.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation codes understood by the datapath.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Mux select encodings.
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // State encoding is visible on the debug port, so values are fixed.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTER = 4'd6,
        ST_EXECUTEI = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Instruction fields.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;

    assign opcode   = ins[6:0];
    assign funct3   = ins[14:12];
    assign funct7_5 = ins[30];

    // Register/immediate fields are consumed by the datapath, not here.
    logic unused_ins_bits;
    assign unused_ins_bits = ^{ins[31], ins[29:15], ins[11:7]};

    // Per-funct3 legality tables, built from the extension parameters.
    logic [7:0] alu_f3_ok;
    logic [7:0] br_f3_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_f3_legal
            // xor/sltu/sll/srl/sra live on funct3 001/011/100/101.
            localparam bit ALU_EXT_F3 = (gi == 1) || (gi == 3) || (gi == 4) || (gi == 5);
            // bne/blt/bge live on funct3 001/100/101; beq (000) is always present.
            localparam bit BR_EXT_F3  = (gi == 1) || (gi == 4) || (gi == 5);
            localparam bit BR_BASE_F3 = (gi == 0);

            assign alu_f3_ok[gi] = ALU_EXT_F3 ? (EXT_ALU != 0) : 1'b1;
            assign br_f3_ok[gi]  = BR_BASE_F3 ? 1'b1
                                 : (BR_EXT_F3 ? (EXT_BRANCH != 0) : 1'b0);
        end
    endgenerate

    // Successor of DECODE: opcode class plus funct3 legality; anything else traps.
    state_t decode_next;
    always_comb begin
        decode_next = ST_TRAP;
        case (opcode)
            OP_LOAD, OP_STORE: begin
                // Only word accesses are implemented.
                if (funct3 == 3'b010) decode_next = ST_MEMADR;
            end
            OP_RTYPE: begin
                if (alu_f3_ok[funct3]) decode_next = ST_EXECUTER;
            end
            OP_IALU: begin
                if (alu_f3_ok[funct3]) decode_next = ST_EXECUTEI;
            end
            OP_BRANCH: begin
                if (br_f3_ok[funct3]) decode_next = ST_BRANCH;
            end
            OP_JAL: begin
                decode_next = ST_JAL;
            end
            default: begin
                decode_next = ST_TRAP;
            end
        endcase
    end

    // ALU operation for R/I execute states from funct3/funct7.
    logic [3:0] alu_decoded;
    always_comb begin
        alu_decoded = ALU_ADD;
        case (funct3)
            // sub only for register form; addi with funct7[5] set stays add.
            3'b000:  alu_decoded = (opcode[5] && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decoded = ALU_SLL;
            3'b010:  alu_decoded = ALU_SLT;
            3'b011:  alu_decoded = ALU_SLTU;
            3'b100:  alu_decoded = ALU_XOR;
            3'b101:  alu_decoded = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decoded = ALU_OR;
            3'b111:  alu_decoded = ALU_AND;
            default: alu_decoded = ALU_ADD;
        endcase
    end

    // Branch condition evaluated from the ALU flags during BRANCH.
    logic branch_taken;
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = ~lt;
            default: branch_taken = 1'b0;
        endcase
    end

    // Immediate format select, purely from the opcode.
    always_comb begin
        imm_src = 2'b00;
        case (opcode)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // State register; reset snaps to FETCH immediately from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Enables before reset gating.
    logic pc_write_comb;
    logic ir_write_comb;
    logic mem_write_comb;
    logic reg_write_comb;
    logic retire_comb;
    logic illegal_comb;

    // Next-state and per-state control outputs; everything idles at 0 unless set.
    always_comb begin
        state_next     = state_reg;
        pc_write_comb  = 1'b0;
        ir_write_comb  = 1'b0;
        mem_write_comb = 1'b0;
        reg_write_comb = 1'b0;
        retire_comb    = 1'b0;
        illegal_comb   = 1'b0;
        adr_src        = 1'b0;
        alu_src_a      = SRCA_PC;
        alu_src_b      = SRCB_RS2;
        result_src     = RES_ALUOUT;
        ALUControl     = ALU_ADD;

        case (state_reg)
            ST_FETCH: begin
                // Read instruction at PC and compute PC+4 in the same cycle.
                adr_src       = 1'b0;
                ir_write_comb = 1'b1;
                alu_src_a     = SRCA_PC;
                alu_src_b     = SRCB_FOUR;
                ALUControl    = ALU_ADD;
                result_src    = RES_ALU;
                pc_write_comb = 1'b1;
                state_next    = ST_DECODE;
            end
            ST_DECODE: begin
                // Speculatively form the branch/jump target oldPC + imm.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                ALUControl = ALU_ADD;
                state_next = decode_next;
            end
            ST_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                ALUControl = ALU_ADD;
                state_next = opcode[5] ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                state_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                result_src     = RES_MEMDATA;
                reg_write_comb = 1'b1;
                retire_comb    = 1'b1;
                state_next     = ST_FETCH;
            end
            ST_MEMWRITE: begin
                adr_src        = 1'b1;
                result_src     = RES_ALUOUT;
                mem_write_comb = 1'b1;
                retire_comb    = 1'b1;
                state_next     = ST_FETCH;
            end
            ST_EXECUTER: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                ALUControl = alu_decoded;
                state_next = ST_ALUWB;
            end
            ST_EXECUTEI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                ALUControl = alu_decoded;
                state_next = ST_ALUWB;
            end
            ST_ALUWB: begin
                result_src     = RES_ALUOUT;
                reg_write_comb = 1'b1;
                retire_comb    = 1'b1;
                state_next     = ST_FETCH;
            end
            ST_BRANCH: begin
                // Compare rs1/rs2; the target computed in DECODE sits in ALUOut.
                alu_src_a     = SRCA_RS1;
                alu_src_b     = SRCB_RS2;
                ALUControl    = ALU_SUB;
                result_src    = RES_ALUOUT;
                pc_write_comb = branch_taken;
                retire_comb   = 1'b1;
                state_next    = ST_FETCH;
            end
            ST_JAL: begin
                // Load the target into PC while computing the link value oldPC+4.
                alu_src_a     = SRCA_OLDPC;
                alu_src_b     = SRCB_FOUR;
                ALUControl    = ALU_ADD;
                result_src    = RES_ALUOUT;
                pc_write_comb = 1'b1;
                state_next    = ST_ALUWB;
            end
            ST_TRAP: begin
                // Parked until reset.
                illegal_comb = 1'b1;
                state_next   = ST_TRAP;
            end
            default: begin
                // Unused encodings recover to FETCH.
                state_next = ST_FETCH;
            end
        endcase
    end

    // Strobes are forced low while reset is held, even though state reads FETCH.
    assign pc_write  = pc_write_comb  & rst_n;
    assign ir_write  = ir_write_comb  & rst_n;
    assign mem_write = mem_write_comb & rst_n;
    assign reg_write = reg_write_comb & rst_n;
    assign retire    = retire_comb    & rst_n;
    assign illegal   = illegal_comb   & rst_n;

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller.
// The driver classifies each instruction with a behavioural model, queues one
// expected control word per cycle, and a negedge monitor pops and compares.
// Two instances: all extensions enabled, and base ISA only.

module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res_src;
        logic [1:0] imm;
        logic [3:0] aluc;
        logic       retire;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t  c;
        string name;
    } exp_t;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                   S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7,
                   S_ALUWB = 8, S_BRANCH = 9, S_JAL = 10, S_TRAP = 11;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v     [2];
    logic [31:0] ins_v     [2];
    logic        zero_v    [2];
    logic        lt_v      [2];
    logic        pc_write_v[2];
    logic        adr_src_v [2];
    logic        ir_write_v[2];
    logic        mem_write_v[2];
    logic        reg_write_v[2];
    logic [1:0]  src_a_v   [2];
    logic [1:0]  src_b_v   [2];
    logic [1:0]  res_src_v [2];
    logic [1:0]  imm_v     [2];
    logic [3:0]  aluc_v    [2];
    logic        retire_v  [2];
    logic        illegal_v [2];
    logic [3:0]  state_v   [2];

    multicycle_controller #(.EXT_BRANCH(1), .EXT_ALU(1)) dut_full (
        .clk(clk), .rst_n(rst_v[0]), .ins(ins_v[0]), .zero(zero_v[0]), .lt(lt_v[0]),
        .pc_write(pc_write_v[0]), .adr_src(adr_src_v[0]), .ir_write(ir_write_v[0]),
        .mem_write(mem_write_v[0]), .reg_write(reg_write_v[0]),
        .alu_src_a(src_a_v[0]), .alu_src_b(src_b_v[0]), .result_src(res_src_v[0]),
        .imm_src(imm_v[0]), .ALUControl(aluc_v[0]), .retire(retire_v[0]),
        .illegal(illegal_v[0]), .state(state_v[0])
    );

    multicycle_controller #(.EXT_BRANCH(0), .EXT_ALU(0)) dut_base (
        .clk(clk), .rst_n(rst_v[1]), .ins(ins_v[1]), .zero(zero_v[1]), .lt(lt_v[1]),
        .pc_write(pc_write_v[1]), .adr_src(adr_src_v[1]), .ir_write(ir_write_v[1]),
        .mem_write(mem_write_v[1]), .reg_write(reg_write_v[1]),
        .alu_src_a(src_a_v[1]), .alu_src_b(src_b_v[1]), .result_src(res_src_v[1]),
        .imm_src(imm_v[1]), .ALUControl(aluc_v[1]), .retire(retire_v[1]),
        .illegal(illegal_v[1]), .state(state_v[1])
    );

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   end_req = 1'b0;
    bit   end_done = 1'b0;

    // ---------------- reference model ----------------

    function automatic int classify(input logic [31:0] i, input bit ext_alu, input bit ext_br);
        logic [6:0] op = i[6:0];
        int f3 = int'(i[14:12]);
        bit alu_ext_op = (f3 == 1) || (f3 == 3) || (f3 == 4) || (f3 == 5);
        case (op)
            7'b0000011: return (f3 == 2) ? K_LW : K_ILL;
            7'b0100011: return (f3 == 2) ? K_SW : K_ILL;
            7'b0110011: return (alu_ext_op && !ext_alu) ? K_ILL : K_R;
            7'b0010011: return (alu_ext_op && !ext_alu) ? K_ILL : K_I;
            7'b1100011: begin
                if (f3 == 0) return K_BR;
                if ((f3 == 1) || (f3 == 4) || (f3 == 5)) return ext_br ? K_BR : K_ILL;
                return K_ILL;
            end
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    // Mnemonic -> ALU code: add0 sub1 and2 or3 xor4 slt5 sltu6 sll7 srl8 sra9.
    function automatic logic [3:0] alu_expect(input logic [31:0] i);
        case (i[14:12])
            3'd0:    return (i[5] && i[30]) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return i[30] ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic taken_expect(input logic [31:0] i, input logic z, input logic l);
        case (i[14:12])
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            3'd5:    return !l;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] imm_expect(input logic [31:0] i);
        if (i[6:0] == 7'b0100011) return 2'b01;
        if (i[6:0] == 7'b1100011) return 2'b10;
        if (i[6:0] == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic ctl_t step(input int st, input logic [31:0] i, input logic z,
                                  input logic l, input bit in_rst);
        ctl_t c = '0;
        c.st  = 4'(st);
        c.imm = imm_expect(i);
        case (st)
            S_FETCH:    begin c.ir_write = 1; c.src_b = 2'b10; c.res_src = 2'b10; c.pc_write = 1; end
            S_DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
            S_MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
            S_MEMREAD:  begin c.adr_src = 1; end
            S_MEMWB:    begin c.res_src = 2'b01; c.reg_write = 1; c.retire = 1; end
            S_MEMWRITE: begin c.adr_src = 1; c.mem_write = 1; c.retire = 1; end
            S_EXECR:    begin c.src_a = 2'b10; c.aluc = alu_expect(i); end
            S_EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.aluc = alu_expect(i); end
            S_ALUWB:    begin c.reg_write = 1; c.retire = 1; end
            S_BRANCH:   begin c.src_a = 2'b10; c.aluc = 4'd1; c.retire = 1;
                              c.pc_write = taken_expect(i, z, l); end
            S_JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1; end
            S_TRAP:     begin c.illegal = 1; end
            default:    ;
        endcase
        if (in_rst) begin
            c.pc_write = 0; c.ir_write = 0; c.mem_write = 0;
            c.reg_write = 0; c.retire = 0; c.illegal = 0;
        end
        return c;
    endfunction

    // ---------------- driver ----------------

    task automatic push(input int sel, input ctl_t c, input string name);
        exp_t e;
        e.c = c;
        e.name = name;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; asserts reset mid-cycle and releases after n cycles.
    task automatic reset_pulse(input int sel, input int n);
        for (int k = 0; k < n; k++) begin
            push(sel, step(S_FETCH, ins_v[sel], zero_v[sel], lt_v[sel], 1'b1), "in_reset");
            if (k == 0) begin
                #2;
                rst_v[sel] = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        rst_v[sel] = 1'b1;
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns the same way.
    task automatic run(input int sel, input logic [31:0] i, input logic z, input logic l,
                       input string tag);
        int kind;
        int seq[$];
        ins_v[sel]  = i;
        zero_v[sel] = z;
        lt_v[sel]   = l;
        kind = classify(i, sel == 0, sel == 0);
        seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        case (kind)
            K_LW:    begin seq.push_back(S_MEMADR); seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
            K_SW:    begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWRITE); end
            K_R:     begin seq.push_back(S_EXECR); seq.push_back(S_ALUWB); end
            K_I:     begin seq.push_back(S_EXECI); seq.push_back(S_ALUWB); end
            K_BR:    begin seq.push_back(S_BRANCH); end
            K_JAL:   begin seq.push_back(S_JAL); seq.push_back(S_ALUWB); end
            default: for (int t = 0; t < 12; t++) seq.push_back(S_TRAP);
        endcase
        $display("[TB] dut%0d %-8s ins=%08h zero=%0b lt=%0b kind=%0d cycles=%0d",
                 sel, tag, i, z, l, kind, seq.size());
        foreach (seq[n]) push(sel, step(seq[n], i, z, l, 1'b0), tag);
        wait_cycles(seq.size());
        if (kind == K_ILL) reset_pulse(sel, 2);
    endtask

    // lw interrupted by reset while in MEMREAD.
    task automatic abort_lw(input int sel);
        logic [31:0] i = 32'h00002083;
        ins_v[sel] = i;
        $display("[TB] dut%0d lw_abort ins=%08h reset in MEMREAD", sel, i);
        push(sel, step(S_FETCH,  i, 1'b0, 1'b0, 1'b0), "lw_abort");
        push(sel, step(S_DECODE, i, 1'b0, 1'b0, 1'b0), "lw_abort");
        push(sel, step(S_MEMADR, i, 1'b0, 1'b0, 1'b0), "lw_abort");
        wait_cycles(3);
        reset_pulse(sel, 3);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 9))
            0: r[6:0] = 7'b0000011;
            1: r[6:0] = 7'b0100011;
            2, 3: r[6:0] = 7'b0110011;
            4, 5: r[6:0] = 7'b0010011;
            6: r[6:0] = 7'b1100011;
            7: r[6:0] = 7'b1101111;
            default: ;
        endcase
        if ((r[6:0] == 7'b0000011 || r[6:0] == 7'b0100011) && $urandom_range(0, 3) != 0)
            r[14:12] = 3'b010;
        return r;
    endfunction

    // ---------------- monitor ----------------

    function automatic ctl_t actual(input int s);
        ctl_t c;
        c.st = state_v[s];         c.pc_write = pc_write_v[s];   c.adr_src = adr_src_v[s];
        c.ir_write = ir_write_v[s]; c.mem_write = mem_write_v[s]; c.reg_write = reg_write_v[s];
        c.src_a = src_a_v[s];      c.src_b = src_b_v[s];         c.res_src = res_src_v[s];
        c.imm = imm_v[s];          c.aluc = aluc_v[s];           c.retire = retire_v[s];
        c.illegal = illegal_v[s];
        return c;
    endfunction

    // Compares one expected cycle per DUT on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        ctl_t a;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = actual(0);
            n_tests++;
            if (a !== e.c) begin
                n_fail++;
                $display("FAIL dut0 %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                         e.name, a.st, a, e.c.st, e.c);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = actual(1);
            n_tests++;
            if (a !== e.c) begin
                n_fail++;
                $display("FAIL dut1 %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                         e.name, a.st, a, e.c.st, e.c);
            end
        end
        if (end_req && !end_done) begin
            n_tests++;
            if (q0.size() + q1.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d pending expectations, expected 0", q0.size() + q1.size());
            end
            end_done = 1'b1;
        end
    end

    // ---------------- stimulus ----------------

    initial begin
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        ins_v[0] = '0;   ins_v[1] = '0;
        zero_v[0] = 0;   zero_v[1] = 0;
        lt_v[0] = 0;     lt_v[1] = 0;

        wait_cycles(2);
        push(0, step(S_FETCH, ins_v[0], 1'b0, 1'b0, 1'b1), "reset_state");
        wait_cycles(1);
        rst_v[0] = 1'b1;

        run(0, 32'h00002083, 1'b0, 1'b0, "lw");
        run(0, 32'h00202023, 1'b0, 1'b0, "sw");
        run(0, 32'h40208033, 1'b0, 1'b0, "sub");
        run(0, 32'h40000093, 1'b0, 1'b0, "addi");
        run(0, 32'h4020D033, 1'b0, 1'b0, "sra");
        run(0, 32'h0020D093, 1'b0, 1'b0, "srli");
        run(0, 32'h00000463, 1'b1, 1'b0, "beq_t");
        run(0, 32'h00001463, 1'b1, 1'b0, "bne_nt");
        run(0, 32'h00004463, 1'b0, 1'b1, "blt_t");
        run(0, 32'h00005463, 1'b0, 1'b1, "bge_nt");
        run(0, 32'h00002463, 1'b1, 1'b0, "beq_f3_2");
        run(0, 32'h008000EF, 1'b0, 1'b0, "jal");
        abort_lw(0);
        run(0, 32'hFFFFFFFF, 1'b0, 1'b0, "allones");
        run(0, 32'h00001083, 1'b0, 1'b0, "lh");
        for (int n = 0; n < 150; n++)
            run(0, rand_ins(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");

        rst_v[1] = 1'b1;
        run(1, 32'h00001463, 1'b1, 1'b0, "bne_base");
        run(1, 32'h00000463, 1'b0, 1'b0, "beq_base");
        run(1, 32'h0020C033, 1'b0, 1'b0, "xor_base");
        run(1, 32'h00208033, 1'b0, 1'b0, "add_base");
        run(1, 32'h00002083, 1'b0, 1'b0, "lw_base");
        for (int n = 0; n < 40; n++)
            run(1, rand_ins(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");

        end_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
